// File: rtl/mtimer_if.sv
// Core-side register bus for the mtimer block: address, lane-shifted write data, byte
// enables, and the registered read data/hit returned one cycle later.
interface mtimer_if;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic [3:0]  memory_write_sections;
    logic [31:0] read_value;
    logic        read_hit;

    modport master (
        output memory_address, memory_write_value, memory_write_sections,
        input  read_value, read_hit
    );

    modport slave (
        input  memory_address, memory_write_value, memory_write_sections,
        output read_value, read_hit
    );
endinterface

// File: rtl/mtimer.sv
// 64-bit machine timer: prescaled mtime counter, NUM_CHANNELS mtimecmp compare channels.
// Optional macro MTIMER_SNAPSHOT_EN latches mtime[63:32] whenever mtime[31:0] is read.
module mtimer #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h80000000,
    parameter int unsigned NUM_CHANNELS   = 1,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                    clk24,
    input  logic                    reset,
    mtimer_if.slave                 bus,
    output logic [NUM_CHANNELS-1:0] timer_interrupt
);

    localparam logic [29:0] BASE_WORD = BASE_ADDRESS[31:2];
    localparam logic [29:0] WIN_WORDS = 30'(4 + 2 * NUM_CHANNELS);

    logic [63:0]               mtime_q, mtime_d;
    logic [63:0]               cmp_q [NUM_CHANNELS];
    logic [63:0]               cmp_d [NUM_CHANNELS];
    logic                      enable_q, enable_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [NUM_CHANNELS-1:0]   irq_q, irq_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      rhit_q, rhit_d;
`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0]               snap_q, snap_d;
`endif

    logic [29:0] word_off_c;
    logic        hit_c;
    logic        wr_c;
    logic        ctrl_wr_c;
    logic        tick_c;
    logic [31:0] ctrl_c;
    logic [31:0] mtime_hi_rd_c;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sect);
        logic [31:0] res;
        res = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sect[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode; addresses below the base wrap to large offsets and miss.
    assign word_off_c = bus.memory_address[31:2] - BASE_WORD;
    assign hit_c      = word_off_c < WIN_WORDS;
    assign wr_c       = hit_c && (bus.memory_write_sections != 4'b0000);
    assign ctrl_wr_c  = wr_c && (word_off_c == 30'd2);
    assign tick_c     = enable_q && (pcnt_q == prescale_q);
    assign ctrl_c     = (32'(prescale_q) << 8) | 32'(enable_q);

`ifdef MTIMER_SNAPSHOT_EN
    assign mtime_hi_rd_c = snap_q;
`else
    assign mtime_hi_rd_c = mtime_q[63:32];
`endif

    always_comb begin
        mtime_d    = mtime_q;
        cmp_d      = cmp_q;
        enable_d   = enable_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        irq_d      = irq_q;
        rdata_d    = 32'd0;
        rhit_d     = hit_c;

        // Any mtime write freezes the whole 64-bit counter for that cycle.
        if (wr_c && word_off_c == 30'd0) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], bus.memory_write_value,
                                        bus.memory_write_sections);
        end else if (wr_c && word_off_c == 30'd1) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], bus.memory_write_value,
                                         bus.memory_write_sections);
        end else if (tick_c) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (ctrl_wr_c) begin
            if (bus.memory_write_sections[0]) enable_d = bus.memory_write_value[0];
            for (int unsigned j = 0; j < PRESCALE_WIDTH; j++) begin
                if (bus.memory_write_sections[2'((8 + j) / 8)])
                    prescale_d[j] = bus.memory_write_value[5'(8 + j)];
            end
        end

        if (ctrl_wr_c || !enable_q || tick_c) pcnt_d = '0;
        else                                  pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);

        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_c && word_off_c == 30'(4 + 2 * i))
                cmp_d[i][31:0] = merge_bytes(cmp_q[i][31:0], bus.memory_write_value,
                                             bus.memory_write_sections);
            if (wr_c && word_off_c == 30'(5 + 2 * i))
                cmp_d[i][63:32] = merge_bytes(cmp_q[i][63:32], bus.memory_write_value,
                                              bus.memory_write_sections);
            irq_d[i] = mtime_q >= cmp_q[i];
        end

        // Reads see pre-write register values.
        if (hit_c) begin
            if (word_off_c == 30'd0)      rdata_d = mtime_q[31:0];
            else if (word_off_c == 30'd1) rdata_d = mtime_hi_rd_c;
            else if (word_off_c == 30'd2) rdata_d = ctrl_c;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                if (word_off_c == 30'(4 + 2 * i)) rdata_d = cmp_q[i][31:0];
                if (word_off_c == 30'(5 + 2 * i)) rdata_d = cmp_q[i][63:32];
            end
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    always_comb begin
        snap_d = snap_q;
        if (hit_c && word_off_c == 30'd0) snap_d = mtime_q[63:32];
    end

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) snap_q <= 32'd0;
        else       snap_q <= snap_d;
    end
`endif

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            mtime_q    <= 64'd0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) cmp_q[i] <= '1;
            enable_q   <= 1'b1;
            prescale_q <= '0;
            pcnt_q     <= '0;
            irq_q      <= '0;
            rdata_q    <= 32'd0;
            rhit_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rhit_q     <= rhit_d;
        end
    end

    assign bus.read_value  = rdata_q;
    assign bus.read_hit    = rhit_q;
    assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer with three compare channels; expectations are hand-derived.
module tb_mtimer;

    localparam logic [31:0] BASE = 32'h80000000;
`ifdef MTIMER_SNAPSHOT_EN
    localparam logic [31:0] HI_AFTER_WRAP = 32'h0;
`else
    localparam logic [31:0] HI_AFTER_WRAP = 32'h1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] irq;
    int         errors = 0;
    int         checks = 0;

    mtimer_if bus ();

    mtimer #(
        .BASE_ADDRESS   (BASE),
        .NUM_CHANNELS   (3),
        .PRESCALE_WIDTH (8)
    ) dut (
        .clk24           (clk),
        .reset           (rst),
        .bus             (bus),
        .timer_interrupt (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] off, input logic [31:0] data, input logic [3:0] sect);
        bus.memory_address        = BASE + off;
        bus.memory_write_value    = data;
        bus.memory_write_sections = sect;
    endtask

    task automatic rd(input logic [31:0] off);
        drive(off, 32'h0, 4'b0000);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd(32'h0);
        cyc();
        cyc();
        chk("reset_rv", bus.read_value, 32'h0);
        chk("reset_hit", 32'(bus.read_hit), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rst = 1'b0;

        // Free-running count, prescale 0: reads lag mtime by one cycle.
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("count_rv", bus.read_value, 32'(k));
            chk("count_hit", 32'(bus.read_hit), 32'h1);
        end
        rd(32'h10);
        cyc();
        chk("cmp0_lo_reset", bus.read_value, 32'hFFFFFFFF);

        // Prescale 3: one increment every 4 cycles.
        drive(32'h8, 32'h00000301, 4'hF);
        cyc();
        rd(32'h0);
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk("prescale3_rv", bus.read_value, 32'(6 + k / 4));
        end

        // Disabled: mtime frozen.
        drive(32'h8, 32'h00000300, 4'hF);
        cyc();
        rd(32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("frozen_rv", bus.read_value, 32'd8);
        end

        // Low-word wrap carries into the high word.
        drive(32'h0, 32'hFFFFFFFE, 4'hF);
        cyc();
        drive(32'h4, 32'h0, 4'hF);
        cyc();
        drive(32'h8, 32'h00000001, 4'hF);
        cyc();
        rd(32'h0);
        cyc();
        chk("wrap_lo0", bus.read_value, 32'hFFFFFFFE);
        cyc();
        chk("wrap_lo1", bus.read_value, 32'hFFFFFFFF);
        rd(32'h4);
        cyc();
        chk("wrap_hi", bus.read_value, HI_AFTER_WRAP);
        rd(32'h0);
        cyc();
        chk("wrap_lo2", bus.read_value, 32'h00000001);

        // Byte-lane write coincident with a tick: no increment, only byte2 changes.
        drive(32'h0, 32'h00AB0000, 4'b0100);
        cyc();
        rd(32'h0);
        cyc();
        chk("bytewr_lo", bus.read_value, 32'h00AB0002);
        rd(32'h4);
        cyc();
        chk("bytewr_hi", bus.read_value, 32'h1);

        // Compare channel 1 at 10.
        drive(32'h8, 32'h0, 4'hF);
        cyc();
        drive(32'h0, 32'd5, 4'hF);
        cyc();
        drive(32'h4, 32'h0, 4'hF);
        cyc();
        drive(32'h18, 32'd10, 4'hF);
        cyc();
        drive(32'h1C, 32'h0, 4'hF);
        cyc();
        rd(32'h40);
        cyc();
        chk("irq_idle", 32'(irq), 32'h0);
        chk("oob_rv", bus.read_value, 32'h0);
        chk("oob_hit", 32'(bus.read_hit), 32'h0);
        drive(32'h8, 32'h1, 4'hF);
        cyc();
        rd(32'h40);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("irq_rise", 32'(irq), (4 + k >= 10) ? 32'h2 : 32'h0);
        end
        drive(32'h18, 32'd100, 4'hF);
        cyc();
        chk("irq_hold", 32'(irq), 32'h2);
        rd(32'h40);
        cyc();
        chk("irq_fall", 32'(irq), 32'h0);

        // Write outside the window is ignored.
        drive(32'h40, 32'hFFFFFFFF, 4'hF);
        cyc();
        chk("oob_wr_rv", bus.read_value, 32'h0);
        chk("oob_wr_hit", 32'(bus.read_hit), 32'h0);
        rd(32'h10);
        cyc();
        chk("oob_cmp0", bus.read_value, 32'hFFFFFFFF);
        rd(32'h8);
        cyc();
        chk("ctrl_rv", bus.read_value, 32'h1);
        chk("ctrl_hit", 32'(bus.read_hit), 32'h1);

        // Asynchronous reset mid-operation.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rv", bus.read_value, 32'h0);
        chk("async_rst_hit", 32'(bus.read_hit), 32'h0);
        rd(32'h0);
        #2 rst = 1'b0;
        cyc();
        chk("post_rst0", bus.read_value, 32'h0);
        cyc();
        chk("post_rst1", bus.read_value, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h80000000, meaning the word-aligned base of the register window.
REQ-002 SHALL have parameter NUM_CHANNELS, default 1, meaning the number of compare channels; legal range is 1..8.
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 8, meaning the width of the prescaler divisor field; legal range is 1..16.
REQ-004 SHALL have port clk24, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port memory_address, input, 32 bits: the byte address presented by the core.
REQ-007 SHALL have port memory_write_value, input, 32 bits: write data already lane-shifted to the address.
REQ-008 SHALL have port memory_write_sections, input, 4 bits: byte-lane write enables; all zero means no write.
REQ-009 SHALL have port read_value, output, 32 bits: registered read data for the word at the previous cycle's address.
REQ-010 SHALL have port read_hit, output, 1 bit: registered flag, 1 when the previous cycle's address decoded into the window.
REQ-011 SHALL have port timer_interrupt, output, NUM_CHANNELS bits: per-channel registered compare flags.

Function
REQ-012 SHALL decode on memory_address[31:2] with the following offsets: +0x0 mtime[31:0]; +0x4 mtime[63:32]; +0x8 control, with bit0 = enable and bits[PRESCALE_WIDTH+7:8] = prescale; +0x10+8*i mtimecmp_i[31:0]; +0x14+8*i mtimecmp_i[63:32].
REQ-013 SHALL treat addresses outside the window, and unused control bits, as reads of 0 and ignored writes.
REQ-014 SHALL have a read latency of exactly 1 cycle: read_value and read_hit SHALL update every cycle from the current memory_address, with no request strobe.
REQ-015 SHALL apply writes per byte lane; lanes whose memory_write_sections bit is 0 SHALL hold their value.
REQ-016 SHALL run the prescaler counter from 0 to prescale and then return to 0, issuing a one-cycle tick on the wrap; prescale = 0 SHALL tick every cycle.
REQ-017 SHALL hold the prescaler counter at 0 and issue no ticks while enable = 0.
REQ-018 SHALL clear the prescaler counter to 0 on any write to control.
REQ-019 SHALL increment mtime by 1 on each tick, wrapping from 64'hFFFFFFFF_FFFFFFFF to 0, with full 64-bit carry from the low word into the high word.
REQ-020 SHALL suppress the increment for the whole 64-bit mtime in any cycle with a write to either mtime word; the written bytes SHALL take the new data and all other bytes SHALL hold.
REQ-021 SHALL set timer_interrupt[i] <= (mtime >= mtimecmp_i), as an unsigned 64-bit compare using current register values, one cycle after those values change.
REQ-022 SHALL let a write to mtimecmp_i that raises it above mtime deassert timer_interrupt[i] on the cycle after the cycle following the write.
REQ-023 SHALL return, on a read of a register written in the same cycle, the pre-write value.

Reset
REQ-024 SHALL, while reset is high, asynchronously force: mtime = 0; every mtimecmp_i = all ones; enable = 1; prescale = 0; prescaler counter = 0; timer_interrupt = 0; read_value = 0; read_hit = 0; snapshot register = 0.
REQ-025 SHALL, on a reset asserted mid-operation, discard any in-flight write or read; the first tick SHALL occur on the first clk24 edge after reset deasserts.

Configuration
REQ-026 SHALL, when macro MTIMER_SNAPSHOT_EN is defined, capture mtime[63:32] into a snapshot register whenever mtime[31:0] is read, and return that snapshot on reads of +0x4.
REQ-027 SHALL, when MTIMER_SNAPSHOT_EN is undefined, omit the snapshot register and return the live mtime[63:32] on reads of +0x4.

Verification
REQ-028 Bench SHALL cover: reset, then read +0x0 on each cycle -> read_hit=1; values 0,1,2,... with 1-cycle latency; mtimecmp0 reads 32'hFFFFFFFF.
REQ-029 Bench SHALL cover: write control = 32'h00000301 (prescale 3) -> mtime increments once every 4 cycles; write enable = 0 -> mtime frozen.
REQ-030 Bench SHALL cover: write mtime = 64'h00000000_FFFFFFFE, then read lo and hi -> hi = 1 after the low-word wrap; with MTIMER_SNAPSHOT_EN, a hi read after a lo read of FFFFFFFF returns 0.
REQ-031 Bench SHALL cover: NUM_CHANNELS=3, mtimecmp1 = 10, others all ones -> only timer_interrupt[1] rises, one cycle after mtime reaches 10; writing mtimecmp1 = 100 -> it falls.
REQ-032 Bench SHALL cover: a byte write (sections 4'b0100, data 32'h00AB0000) to +0x0 coincident with a tick -> byte2 = AB, other bytes unchanged, no increment that cycle.
REQ-033 Bench SHALL cover: read of address BASE+0x40 with NUM_CHANNELS=1 -> read_hit=0 and read_value=0; a write there -> no state change.
